// File: rtl/reg_alu_pkg.sv
// Shared types for the pipelined register-file/ALU datapath.
// Opcode encoding and flag bit positions.
package reg_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_LOAD = 3'b111
  } alu_op_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

endpackage

// File: rtl/reg_alu_pipe_if.sv
// Issue and result handshakes of reg_alu_pipe.
// master = control side, slave = datapath.
interface reg_alu_pipe_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic              in_we;
  logic [ADDR_W-1:0] in_wa;
  logic [ADDR_W-1:0] in_ra;
  logic [ADDR_W-1:0] in_rb;
  logic [DATA_W-1:0] in_imm;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [ADDR_W-1:0] res_wa;
  logic              res_we;
  logic [2:0]        res_flags;

  modport master (
    output in_valid, in_op, in_we,
    output in_wa, in_ra, in_rb, in_imm,
    input  in_ready,
    input  res_valid, res_data, res_wa,
    input  res_we, res_flags,
    output res_ready
  );

  modport slave (
    input  in_valid, in_op, in_we,
    input  in_wa, in_ra, in_rb, in_imm,
    output in_ready,
    output res_valid, res_data, res_wa,
    output res_we, res_flags,
    input  res_ready
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: eight ops plus
// {carry, negative, zero} flags.
module alu_core
  import reg_alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] y,
  output logic [2:0]        flags
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] dif;
  logic [SH_W-1:0] sh;
  logic            c;

  // evaluate op; carry only for ADD/SUB
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    dif = {1'b0, a} - {1'b0, b};
    sh  = b[SH_W-1:0];
    y   = '0;
    c   = 1'b0;
    unique case (op)
      OP_ADD: begin
        y = sum[DATA_W-1:0];
        c = sum[DATA_W];
      end
      OP_SUB: begin
        y = dif[DATA_W-1:0];
        c = dif[DATA_W];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL:  y = a << sh;
      OP_SHR:  y = a >> sh;
      OP_LOAD: y = imm;
    endcase
    flags         = '0;
    flags[FLAG_C] = c;
    flags[FLAG_N] = y[DATA_W-1];
    flags[FLAG_Z] = (y == '0);
  end

endmodule

// File: rtl/reg_alu_pipe.sv
// Two-stage register-file/ALU pipeline with
// full operand bypass and result handshake.
module reg_alu_pipe
  import reg_alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 32,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input logic          clk,
  input logic          reset,
  reg_alu_pipe_if.slave bus
);

  typedef struct packed {
    alu_op_t           op;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
  } s1_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [2:0]        flags;
    logic [ADDR_W-1:0] wa;
    logic              we;
  } s2_t;

  logic [DATA_W-1:0] rf [NREGS];

  s1_t  s1;
  s2_t  s2;
  logic s1_valid;
  logic s2_valid;

  logic s2_ret;
  logic s1_adv;
  logic ready;
  logic accept;

  logic [DATA_W-1:0] alu_y;
  logic [2:0]        alu_f;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  alu_core #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op   (s1.op),
    .a    (s1.a),
    .b    (s1.b),
    .imm  (s1.imm),
    .y    (alu_y),
    .flags(alu_f)
  );

  // handshake and stage-advance conditions
  always_comb begin
    s2_ret = s2_valid && bus.res_ready;
    s1_adv = s1_valid && (!s2_valid || s2_ret);
    ready  = !s1_valid || s1_adv;
    accept = bus.in_valid && ready;
  end

  // operand read: S1 result > S2 result > array
  always_comb begin
    op_a = rf[bus.in_ra];
    op_b = rf[bus.in_rb];
    if (s2_valid && s2.we && s2.wa == bus.in_ra)
      op_a = s2.data;
    if (s2_valid && s2.we && s2.wa == bus.in_rb)
      op_b = s2.data;
    if (s1_valid && s1.we && s1.wa == bus.in_ra)
      op_a = alu_y;
    if (s1_valid && s1.we && s1.wa == bus.in_rb)
      op_b = alu_y;
  end

  // S1: capture op and operands on acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (ready) begin
      s1_valid <= accept;
      if (accept) begin
        s1.op  <= alu_op_t'(bus.in_op);
        s1.we  <= bus.in_we;
        s1.wa  <= bus.in_wa;
        s1.a   <= op_a;
        s1.b   <= op_b;
        s1.imm <= bus.in_imm;
      end
    end
  end

  // S2: register ALU result, hold under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2       <= '0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2.data  <= alu_y;
      s2.flags <= alu_f;
      s2.wa    <= s1.wa;
      s2.we    <= s1.we;
    end else if (s2_ret) begin
      s2_valid <= 1'b0;
    end
  end

  // register file: write back on retirement
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        rf[i] <= '0;
    end else if (s2_ret && s2.we) begin
      rf[s2.wa] <= s2.data;
    end
  end

  // outputs
  always_comb begin
    bus.in_ready  = ready;
    bus.res_valid = s2_valid;
    bus.res_data  = s2.data;
    bus.res_flags = s2.flags;
    bus.res_wa    = s2.wa;
    bus.res_we    = s2_valid && s2.we;
  end

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Directed-vector bench for reg_alu_pipe:
// vector table plus backpressure/reset sequences.
module tb_reg_alu_pipe;
  import reg_alu_pkg::*;

  logic clk = 1'b0;
  logic reset;

  reg_alu_pipe_if #(.DATA_W(16), .ADDR_W(5)) bus ();

  reg_alu_pipe #(
    .DATA_W(16),
    .NREGS (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        we;
    logic [4:0]  wa;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [15:0] imm;
    logic [15:0] data;
    logic [2:0]  flags;
  } vec_t;

  localparam int NV = 24;
  vec_t v [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(
    input logic we, input logic [4:0] wa,
    input logic [2:0] f, input logic [15:0] d);
    return {7'b0, we, wa, f, d};
  endfunction

  function automatic logic [31:0] res_pk();
    return pk(bus.res_we, bus.res_wa,
              bus.res_flags, bus.res_data);
  endfunction

  function automatic vec_t mk(
    input logic [2:0] op, input logic we,
    input logic [4:0] wa, input logic [4:0] ra,
    input logic [4:0] rb, input logic [15:0] imm,
    input logic [15:0] d, input logic [2:0] f);
    vec_t t;
    t.op = op; t.we = we; t.wa = wa;
    t.ra = ra; t.rb = rb; t.imm = imm;
    t.data = d; t.flags = f;
    return t;
  endfunction

  task automatic drive(input logic [2:0] op,
                       input logic we,
                       input logic [4:0] wa,
                       input logic [4:0] ra,
                       input logic [4:0] rb,
                       input logic [15:0] imm);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_we    = we;
    bus.in_wa    = wa;
    bus.in_ra    = ra;
    bus.in_rb    = rb;
    bus.in_imm   = imm;
  endtask

  initial begin
    // flags are {c,n,z}
    v[0]  = mk(OP_LOAD, 1, 1, 0, 0, 16'h0005, 16'h0005, 3'b000);
    v[1]  = mk(OP_LOAD, 1, 2, 0, 0, 16'h0003, 16'h0003, 3'b000);
    v[2]  = mk(OP_ADD,  1, 3, 1, 2, 16'h0000, 16'h0008, 3'b000);
    v[3]  = mk(OP_SUB,  1, 4, 2, 1, 16'h0000, 16'hFFFE, 3'b110);
    v[4]  = mk(OP_SUB,  1, 5, 1, 1, 16'h0000, 16'h0000, 3'b001);
    v[5]  = mk(OP_LOAD, 1, 1, 0, 0, 16'h0001, 16'h0001, 3'b000);
    v[6]  = mk(OP_ADD,  1, 1, 1, 1, 16'h0000, 16'h0002, 3'b000);
    v[7]  = mk(OP_ADD,  1, 1, 1, 1, 16'h0000, 16'h0004, 3'b000);
    v[8]  = mk(OP_ADD,  1, 1, 1, 1, 16'h0000, 16'h0008, 3'b000);
    v[9]  = mk(OP_ADD,  1, 1, 1, 1, 16'h0000, 16'h0010, 3'b000);
    v[10] = mk(OP_LOAD, 1, 1, 0, 0, 16'h8001, 16'h8001, 3'b010);
    v[11] = mk(OP_LOAD, 1, 2, 0, 0, 16'h0011, 16'h0011, 3'b000);
    v[12] = mk(OP_SHL,  1, 6, 1, 2, 16'h0000, 16'h0002, 3'b000);
    v[13] = mk(OP_LOAD, 1, 7, 0, 0, 16'h8000, 16'h8000, 3'b010);
    v[14] = mk(OP_LOAD, 1, 8, 0, 0, 16'h000F, 16'h000F, 3'b000);
    v[15] = mk(OP_SHR,  1, 9, 7, 8, 16'h0000, 16'h0001, 3'b000);
    v[16] = mk(OP_AND,  1, 10, 7, 1, 16'h0000, 16'h8000, 3'b010);
    v[17] = mk(OP_OR,   1, 11, 8, 2, 16'h0000, 16'h001F, 3'b000);
    v[18] = mk(OP_XOR,  1, 12, 1, 1, 16'h0000, 16'h0000, 3'b001);
    v[19] = mk(OP_ADD,  1, 13, 7, 7, 16'h0000, 16'h0000, 3'b101);
    v[20] = mk(OP_LOAD, 1, 0, 0, 0, 16'hFFFF, 16'hFFFF, 3'b010);
    v[21] = mk(OP_ADD,  1, 14, 0, 2, 16'h0000, 16'h0010, 3'b100);
    v[22] = mk(OP_ADD,  0, 31, 8, 8, 16'h0000, 16'h001E, 3'b000);
    v[23] = mk(OP_XOR,  1, 30, 31, 8, 16'h0000, 16'h000F, 3'b000);

    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_we     = 1'b0;
    bus.in_wa     = '0;
    bus.in_ra     = '0;
    bus.in_rb     = '0;
    bus.in_imm    = '0;
    bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res", res_pk(), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // back-to-back table, result two edges after issue
    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 2) begin
        chk($sformatf("v%0d_valid", i - 2),
            32'(bus.res_valid), 32'd1);
        chk($sformatf("v%0d_res", i - 2), res_pk(),
            pk(v[i-2].we, v[i-2].wa,
               v[i-2].flags, v[i-2].data));
      end
      if (i < NV) begin
        drive(v[i].op, v[i].we, v[i].wa,
              v[i].ra, v[i].rb, v[i].imm);
        #1;
        chk($sformatf("v%0d_ready", i),
            32'(bus.in_ready), 32'd1);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("drain_valid", 32'(bus.res_valid), 32'd0);

    // backpressure: two accepted, third blocked
    bus.res_ready = 1'b0;
    drive(OP_LOAD, 1, 20, 0, 0, 16'hAAAA);
    #1 chk("bp_rdy_a", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    drive(OP_LOAD, 1, 21, 0, 0, 16'h5555);
    #1 chk("bp_rdy_b", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    drive(OP_ADD, 1, 22, 20, 21, 16'h0000);
    #1 chk("bp_rdy_c", 32'(bus.in_ready), 32'd0);
    chk("bp_hold0", res_pk(),
        pk(1, 20, 3'b010, 16'hAAAA));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp_rdy%0d", k),
          32'(bus.in_ready), 32'd0);
      chk($sformatf("bp_valid%0d", k),
          32'(bus.res_valid), 32'd1);
      chk($sformatf("bp_hold%0d", k), res_pk(),
          pk(1, 20, 3'b010, 16'hAAAA));
    end
    bus.res_ready = 1'b1;
    #1 chk("bp_release", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_res_b", res_pk(),
        pk(1, 21, 3'b000, 16'h5555));
    @(negedge clk);
    chk("bp_res_c", res_pk(),
        pk(1, 22, 3'b010, 16'hFFFF));
    @(negedge clk);
    chk("bp_empty", 32'(bus.res_valid), 32'd0);
    // read retired values back from the array
    drive(OP_ADD, 1, 15, 22, 20, 16'h0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_rf_rd", res_pk(),
        pk(1, 15, 3'b110, 16'hAAA9));

    // reset with S1 and S2 occupied
    @(negedge clk);
    bus.res_ready = 1'b0;
    drive(OP_LOAD, 1, 0, 0, 0, 16'h7777);
    @(negedge clk);
    drive(OP_LOAD, 1, 1, 0, 0, 16'h1111);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 chk("pre_rst_valid", 32'(bus.res_valid), 32'd1);
    reset = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_res", res_pk(), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    drive(OP_ADD, 1, 2, 0, 0, 16'h0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(bus.res_valid), 32'd1);
    chk("post_rst_r0", res_pk(),
        pk(1, 2, 3'b001, 16'h0000));
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
